// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared CPU constants and div_seq state encoding
package div_seq_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } divState_t;

  // Magnitude of a signed operand, one bit wider so that |-2^31| is exact
  function automatic logic [WIDTH:0] absVal(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? (~ext + {{WIDTH{1'b0}}, 1'b1}) : ext;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration
module div_step
  import div_seq_pkg::*;
(
  input  logic [WIDTH-1:0] remIn,
  input  logic             nextBit,
  input  logic [WIDTH:0]   divisorMag,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift in the next dividend bit and subtract the divisor when it fits
  always_comb begin
    shifted = {remIn, nextBit};
    diff    = shifted - divisorMag;
    qBit    = (shifted >= divisorMag);
    remOut  = WIDTH'(qBit ? diff : shifted);
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed 32-bit divider (MIPS DIV semantics)
module div_seq
  import div_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  divState_t        state;
  divState_t        stateNext;
  logic [CNT_W-1:0] iterCount;
  logic [WIDTH-1:0] workQ;      // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] remStep;
  logic [WIDTH:0]   divisorMag;
  logic [WIDTH:0]   divisorAbs;
  logic             signQ;
  logic             signR;
  logic             qBit;
  logic             zeroReq;
  logic             accept;
  logic             lastIter;

  assign divisorAbs = absVal(divisor);
  assign zeroReq    = (state == IDLE) && start && (divisor == '0);
  assign accept     = (state == IDLE) && start && (divisor != '0);
  assign lastIter   = (iterCount == CNT_W'(DIV_ITERS - 1));
  assign busy       = (state != IDLE);

  div_step uStep (
    .remIn      (remReg),
    .nextBit    (workQ[WIDTH-1]),
    .divisorMag (divisorMag),
    .remOut     (remStep),
    .qBit       (qBit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state: IDLE -> CALC on an accepted start, 32 CALC cycles, one FIX cycle
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = CALC;
      CALC:    if (lastIter) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, sign fix-up and result commit
  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      iterCount  <= '0;
      workQ      <= '0;
      remReg     <= '0;
      divisorMag <= '0;
      signQ      <= 1'b0;
      signR      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (zeroReq) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else if (accept) begin
            workQ      <= WIDTH'(absVal(dividend));
            divisorMag <= divisorAbs;
            signQ      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            signR      <= dividend[WIDTH-1];
            div_zero   <= 1'b0;
            remReg     <= '0;
            iterCount  <= '0;
          end
        end
        CALC: begin
          remReg    <= remStep;
          workQ     <= {workQ[WIDTH-2:0], qBit};
          iterCount <= iterCount + CNT_W'(1);
        end
        FIX: begin
          lo   <= signQ ? -workQ : workQ;
          hi   <= signR ? -remReg : remReg;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
